simd_decode_stage: RTL and testbench
====================================

Name: simd_decode_stage

Overview:
- Registered, flow-controlled SIMD ALU decode stage.
- Sits between the issue/wavefront pool and the SIMD operand-read stage.
- Decodes opcode, SGPR destination and NUM_SRC source addresses into write enables, per-source mux selects and VGPR read enables.
- Unlike the previous purely combinational decoder, it is pipelined with a valid/ready handshake and an output FIFO. It flags unsupported opcodes and source encodings instead of emitting X, and keeps a saturating illegal-instruction counter.

Parameters:
- NUM_SRC, 3, number of source operand addresses decoded (1..4).
- TAG_W, 6, width of the opaque tag (wavefront id) carried alongside the instruction.
- FIFO_DEPTH, 2, output queue entries (power of two, at least 2).
- CNT_W, 16, illegal-instruction counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction presented.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_opcode  in  32  {format[31:24], opcode[11:0]}; format values use the shared `ALU_*_FORMAT` definitions.
- in_sgpr_dest_addr  in  12  encoded destination.
- in_source_addr  in  NUM_SRC*12  packed; source i occupies bits [12i+11:12i].
- in_tag  in  TAG_W  passthrough tag.
- out_valid  out  1  decoded entry at FIFO head.
- out_ready  in  1  consumer accepts the head entry.
- out_vcc_wr_en, out_vgpr_wr_en, out_sgpr_wr_en  out  1 each  write enables.
- out_source_mux_select  out  NUM_SRC*4  packed mux selects.
- out_vgpr_source_rd_en  out  NUM_SRC  per-source VGPR read enable.
- out_sgpr_rd_en, out_exec_rd_en  out  1 each  constant 1 while out_valid, else 0.
- out_illegal  out  1  the entry had an unsupported opcode or source.
- out_tag  out  TAG_W  tag of the entry.
- illegal_count  out  CNT_W  saturating count of illegal instructions accepted.

Behaviour:
- Accept: in_valid && in_ready. Decode is combinational on the inputs; the result is written into the FIFO on the accept edge.
- Latency: the accepted entry appears at the FIFO head with out_valid=1 one cycle after accept when the FIFO was empty.
- Pop: out_valid && out_ready.
- in_ready = !full, purely from registered state.
- Simultaneous push and pop when full: the push is refused (in_ready=0 already). When the FIFO is empty, the same-cycle push is not visible until the next cycle; there is no bypass.
- out_valid and all out_* fields are driven from the head entry. When empty they read 0.
- Opcode table, giving {vcc, vgpr, sgpr}:
  - VOP1 0x001: 010.
  - VOP2 0x025, 0x026: 110.
  - VOP2 0x01B, 0x01C, 0x01A, 0x014, 0x013, 0x016, 0x000, 0x009: 010.
  - VOP3A 0x11B, 0x114, 0x113, 0x16A, 0x109, 0x16B, 0x169, 0x148, 0x14A: 010.
  - VOPC 0x080–0x087 and 0x0C0–0x0C7: 100.
  - VOP3A 0x080–0x087 and 0x0C0–0x0C7: 101.
- Any other opcode: {0,0,0}, illegal=1.
- VOP3A destination override, applied only when the opcode is legal:
  - sgpr_dest == 12'hE01 forces vcc=1, sgpr=0.
  - sgpr_dest matching 12'b110?_????_???? forces vcc=0, sgpr=1.
- Source decode per source:
  - 0x7FF: select 0.
  - 12'b00??_????_????: select 1.
  - 12'b10??_????_????: select 2, rd_en=1.
  - 12'b110?_????_????: select 3.
  - 0xE01 → 4, 0xE02 → 5, 0xE04 → 6, 0xE08 → 7, 0xE10 → 8, 0xE20 → 9, 0xE40 → 10, 0xE80 → 11.
  - Any other encoding: select 4'hF, rd_en=0, illegal=1.
- rd_en is 0 for every legal select other than 2.
- The literal check (0x7FF) takes priority over the constant range.
- illegal_count increments on each accepted illegal instruction and saturates at all-ones. It is not cleared by pops.
- rst: FIFO empties (pointers and count to 0), out_valid=0, all out_* fields 0, illegal_count=0, in_ready=0 during the reset cycle and 1 from the next cycle. Any accept or pop in the reset cycle is discarded.

Test Plan:
- Reset, then push VOP2 0x025 with sources {0x7FF, 0x805, 0xC03} and tag 5, out_ready=1 → next cycle out_valid=1; vcc=1, vgpr=1, sgpr=0; selects {0, 2, 3}; rd_en=3'b010; tag=5; illegal=0.
- VOP3A 0x081 with dest 0xE01, then the same opcode with dest 0xC04 → first entry {vcc=1, sgpr=0}, second {vcc=0, sgpr=1}; vgpr=0 for both.
- Opcode VOP2 0x0FF plus a source of 0xE03 → illegal=1, all write enables 0, that source select=0xF with rd_en=0, illegal_count=1. Push 2^CNT_W+3 illegal instructions with a small-CNT_W build → count holds at all-ones.
- out_ready=0, push 3 instructions with FIFO_DEPTH=2 → in_ready drops after the 2nd accept and the 3rd is held. Raise out_ready → entries drain in order with their tags and the 3rd is accepted.
- Assert rst while the FIFO holds 2 entries and in_valid=1 → next cycle out_valid=0, illegal_count=0, and the pending input is not captured.
- NUM_SRC=4 build: a 4th source of 0xE80 → select slice [15:12]=0xB, rd_en[3]=0.

Source files
------------

// File: rtl/simd_decode_stage.sv
// ============================================================================
// Module   : simd_decode_stage
// Function : Registered SIMD ALU decode stage with valid/ready flow control,
//            an output FIFO and a saturating illegal-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module simd_decode_stage #(
   parameter int         NUM_SRC          = 3,
   parameter int         TAG_W            = 6,
   parameter int         FIFO_DEPTH       = 2,
   parameter int         CNT_W            = 16,
   parameter logic [7:0] ALU_VOP3A_FORMAT = 8'h01,
   parameter logic [7:0] ALU_VOP1_FORMAT  = 8'h04,
   parameter logic [7:0] ALU_VOP2_FORMAT  = 8'h08,
   parameter logic [7:0] ALU_VOPC_FORMAT  = 8'h10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_opcode,
   input  logic [11:0]            in_sgpr_dest_addr,
   input  logic [NUM_SRC*12-1:0]  in_source_addr,
   input  logic [TAG_W-1:0]       in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_vcc_wr_en,
   output logic                   out_vgpr_wr_en,
   output logic                   out_sgpr_wr_en,
   output logic [NUM_SRC*4-1:0]   out_source_mux_select,
   output logic [NUM_SRC-1:0]     out_vgpr_source_rd_en,
   output logic                   out_sgpr_rd_en,
   output logic                   out_exec_rd_en,
   output logic                   out_illegal,
   output logic [TAG_W-1:0]       out_tag,
   output logic [CNT_W-1:0]       illegal_count
);

   localparam int C_AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int C_ENT_W = TAG_W + 1 + NUM_SRC + NUM_SRC*4 + 3;
   localparam logic [C_AW:0] C_DEPTH = (C_AW+1)'(FIFO_DEPTH);

   logic [7:0]              w_fmt;
   logic [11:0]             w_op;
   logic                    w_cmp_range;
   logic                    w_vcc, w_vgpr, w_sgpr, w_op_ok;
   logic [NUM_SRC*4-1:0]    w_sel_flat;
   logic [NUM_SRC-1:0]      w_rd;
   logic [NUM_SRC-1:0]      w_src_bad;
   logic                    w_illegal;
   logic [C_ENT_W-1:0]      w_entry;
   logic [C_ENT_W-1:0]      w_head;
   logic                    w_full, w_push, w_pop;
   logic                    w_unused_opcode;

   logic [C_ENT_W-1:0]      r_mem [FIFO_DEPTH];
   logic [C_AW-1:0]         r_wr_ptr, r_rd_ptr;
   logic [C_AW:0]           r_count;
   logic [CNT_W-1:0]        r_illegal_count;

   assign w_fmt           = in_opcode[31:24];
   assign w_op            = in_opcode[11:0];
   assign w_unused_opcode = ^in_opcode[23:12];
   assign w_cmp_range     = (w_op >= 12'h080 && w_op <= 12'h087) ||
                            (w_op >= 12'h0C0 && w_op <= 12'h0C7);

   always_comb begin
      w_vcc   = 1'b0;
      w_vgpr  = 1'b0;
      w_sgpr  = 1'b0;
      w_op_ok = 1'b0;
      if (w_fmt == ALU_VOP1_FORMAT) begin
         if (w_op == 12'h001) begin
            w_vgpr  = 1'b1;
            w_op_ok = 1'b1;
         end
      end else if (w_fmt == ALU_VOP2_FORMAT) begin
         case (w_op)
            12'h025, 12'h026: begin
               w_vcc   = 1'b1;
               w_vgpr  = 1'b1;
               w_op_ok = 1'b1;
            end
            12'h01B, 12'h01C, 12'h01A, 12'h014,
            12'h013, 12'h016, 12'h000, 12'h009: begin
               w_vgpr  = 1'b1;
               w_op_ok = 1'b1;
            end
            default: ;
         endcase
      end else if (w_fmt == ALU_VOP3A_FORMAT) begin
         case (w_op)
            12'h11B, 12'h114, 12'h113, 12'h16A, 12'h109,
            12'h16B, 12'h169, 12'h148, 12'h14A: begin
               w_vgpr  = 1'b1;
               w_op_ok = 1'b1;
            end
            default: begin
               if (w_cmp_range) begin
                  w_vcc   = 1'b1;
                  w_sgpr  = 1'b1;
                  w_op_ok = 1'b1;
               end
            end
         endcase
         // VOP3A may redirect its carry/compare result to VCC or an SGPR.
         if (w_op_ok) begin
            if (in_sgpr_dest_addr == 12'hE01) begin
               w_vcc  = 1'b1;
               w_sgpr = 1'b0;
            end else if (in_sgpr_dest_addr[11:9] == 3'b110) begin
               w_vcc  = 1'b0;
               w_sgpr = 1'b1;
            end
         end
      end else if (w_fmt == ALU_VOPC_FORMAT) begin
         if (w_cmp_range) begin
            w_vcc   = 1'b1;
            w_op_ok = 1'b1;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
         logic [11:0] w_addr;
         logic [3:0]  w_sel;
         logic        w_rd_en;
         logic        w_bad;

         assign w_addr = in_source_addr[12*gi +: 12];

         always_comb begin
            w_sel   = 4'h0;
            w_rd_en = 1'b0;
            w_bad   = 1'b0;
            // The literal code sits ahead of the constant range on purpose.
            if (w_addr == 12'h7FF) begin
               w_sel = 4'h0;
            end else begin
               casez (w_addr)
                  12'b00??_????_????: w_sel = 4'h1;
                  12'b10??_????_????: begin
                     w_sel   = 4'h2;
                     w_rd_en = 1'b1;
                  end
                  12'b110?_????_????: w_sel = 4'h3;
                  12'hE01:            w_sel = 4'h4;
                  12'hE02:            w_sel = 4'h5;
                  12'hE04:            w_sel = 4'h6;
                  12'hE08:            w_sel = 4'h7;
                  12'hE10:            w_sel = 4'h8;
                  12'hE20:            w_sel = 4'h9;
                  12'hE40:            w_sel = 4'hA;
                  12'hE80:            w_sel = 4'hB;
                  default: begin
                     w_sel = 4'hF;
                     w_bad = 1'b1;
                  end
               endcase
            end
         end

         assign w_sel_flat[4*gi +: 4] = w_sel;
         assign w_rd[gi]              = w_rd_en;
         assign w_src_bad[gi]         = w_bad;
      end
   endgenerate

   assign w_illegal = !w_op_ok || (|w_src_bad);
   assign w_entry   = {in_tag, w_illegal, w_rd, w_sel_flat, w_vcc, w_vgpr, w_sgpr};

   assign w_full   = (r_count == C_DEPTH);
   assign in_ready = !rst && !w_full;
   assign w_push   = in_valid && in_ready;
   assign w_pop    = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr        <= '0;
         r_rd_ptr        <= '0;
         r_count         <= '0;
         r_illegal_count <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_push && w_illegal && (r_illegal_count != {CNT_W{1'b1}})) begin
            r_illegal_count <= r_illegal_count + 1'b1;
         end
      end
   end

   assign out_valid = (r_count != '0);
   assign w_head    = out_valid ? r_mem[r_rd_ptr] : '0;

   assign out_sgpr_wr_en        = w_head[0];
   assign out_vgpr_wr_en        = w_head[1];
   assign out_vcc_wr_en         = w_head[2];
   assign out_source_mux_select = w_head[3 +: NUM_SRC*4];
   assign out_vgpr_source_rd_en = w_head[3 + NUM_SRC*4 +: NUM_SRC];
   assign out_illegal           = w_head[3 + NUM_SRC*5];
   assign out_tag               = w_head[4 + NUM_SRC*5 +: TAG_W];
   assign out_sgpr_rd_en        = out_valid;
   assign out_exec_rd_en        = out_valid;
   assign illegal_count         = r_illegal_count;

endmodule

`default_nettype wire

// File: tb/tb_simd_decode_stage.sv
// ============================================================================
// Module   : tb_simd_decode_stage
// Function : Scoreboard bench for simd_decode_stage (default build plus a
//            NUM_SRC=4 / CNT_W=3 build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_simd_decode_stage;

   localparam logic [7:0] F_VOP3A = 8'h01;
   localparam logic [7:0] F_VOP1  = 8'h04;
   localparam logic [7:0] F_VOP2  = 8'h08;
   localparam logic [7:0] F_VOPC  = 8'h10;
   localparam logic [11:0] L      = 12'h7FF;

   typedef struct {
      logic [2:0]  we;
      logic [11:0] sel;
      logic [2:0]  rd;
      logic        ill;
      logic [5:0]  tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_opcode;
   logic [11:0] in_sgpr_dest_addr;
   logic [35:0] in_source_addr;
   logic [5:0]  in_tag, out_tag;
   logic        out_vcc_wr_en, out_vgpr_wr_en, out_sgpr_wr_en;
   logic [11:0] out_source_mux_select;
   logic [2:0]  out_vgpr_source_rd_en;
   logic        out_sgpr_rd_en, out_exec_rd_en, out_illegal;
   logic [15:0] illegal_count;

   logic        s_valid, s_ready, s_out_valid;
   logic [31:0] s_opcode;
   logic [11:0] s_dest;
   logic [47:0] s_src;
   logic [5:0]  s_tag, s_out_tag;
   logic        s_vcc, s_vgpr, s_sgpr, s_sgpr_rd, s_exec_rd, s_ill;
   logic [15:0] s_sel;
   logic [3:0]  s_rd;
   logic [2:0]  s_count;

   int   n_asserts = 0;
   int   n_fail    = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   simd_decode_stage #(
      .NUM_SRC(3), .TAG_W(6), .FIFO_DEPTH(2), .CNT_W(16),
      .ALU_VOP3A_FORMAT(F_VOP3A), .ALU_VOP1_FORMAT(F_VOP1),
      .ALU_VOP2_FORMAT(F_VOP2), .ALU_VOPC_FORMAT(F_VOPC)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_sgpr_dest_addr(in_sgpr_dest_addr),
      .in_source_addr(in_source_addr), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_vcc_wr_en(out_vcc_wr_en), .out_vgpr_wr_en(out_vgpr_wr_en),
      .out_sgpr_wr_en(out_sgpr_wr_en),
      .out_source_mux_select(out_source_mux_select),
      .out_vgpr_source_rd_en(out_vgpr_source_rd_en),
      .out_sgpr_rd_en(out_sgpr_rd_en), .out_exec_rd_en(out_exec_rd_en),
      .out_illegal(out_illegal), .out_tag(out_tag),
      .illegal_count(illegal_count)
   );

   simd_decode_stage #(
      .NUM_SRC(4), .TAG_W(6), .FIFO_DEPTH(2), .CNT_W(3),
      .ALU_VOP3A_FORMAT(F_VOP3A), .ALU_VOP1_FORMAT(F_VOP1),
      .ALU_VOP2_FORMAT(F_VOP2), .ALU_VOPC_FORMAT(F_VOPC)
   ) dut_s (
      .clk(clk), .rst(rst),
      .in_valid(s_valid), .in_ready(s_ready),
      .in_opcode(s_opcode), .in_sgpr_dest_addr(s_dest),
      .in_source_addr(s_src), .in_tag(s_tag),
      .out_valid(s_out_valid), .out_ready(1'b1),
      .out_vcc_wr_en(s_vcc), .out_vgpr_wr_en(s_vgpr),
      .out_sgpr_wr_en(s_sgpr),
      .out_source_mux_select(s_sel),
      .out_vgpr_source_rd_en(s_rd),
      .out_sgpr_rd_en(s_sgpr_rd), .out_exec_rd_en(s_exec_rd),
      .out_illegal(s_ill), .out_tag(s_out_tag),
      .illegal_count(s_count)
   );

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
      n_asserts++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
      end
   endtask

   function automatic exp_t mk(input logic [2:0] we, input logic [11:0] sel,
                               input logic [2:0] rd, input logic ill, input logic [5:0] tag);
      exp_t e;
      e.we = we; e.sel = sel; e.rd = rd; e.ill = ill; e.tag = tag;
      return e;
   endfunction

   // Scoreboard: compare the FIFO head whenever the consumer takes it.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 64'(out_tag), 64'hFFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("head_tag", 64'(out_tag), 64'(e.tag));
            check("head_we", 64'({out_vcc_wr_en, out_vgpr_wr_en, out_sgpr_wr_en}), 64'(e.we));
            check("head_sel", 64'(out_source_mux_select), 64'(e.sel));
            check("head_rd", 64'(out_vgpr_source_rd_en), 64'(e.rd));
            check("head_illegal", 64'(out_illegal), 64'(e.ill));
            check("head_sgpr_exec_rd", 64'({out_sgpr_rd_en, out_exec_rd_en}), 64'h3);
         end
      end
   end

   task automatic drive(input logic [7:0] fmt, input logic [11:0] op, input logic [11:0] dest,
                        input logic [35:0] src, input logic [5:0] tag);
      in_opcode         = {fmt, 12'h000, op};
      in_sgpr_dest_addr = dest;
      in_source_addr    = src;
      in_tag            = tag;
      in_valid          = 1'b1;
   endtask

   task automatic wait_accept(input exp_t e);
      bit done = 0;
      for (int n = 0; n < 20 && !done; n++) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(e);
            done = 1;
         end
      end
      if (!done) check("accept_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
         @(posedge clk); #1;
      end
      check("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int acc;
      rst = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
      in_opcode = '0; in_sgpr_dest_addr = '0; in_source_addr = '0; in_tag = '0;
      s_valid = 1'b0; s_opcode = '0; s_dest = '0; s_src = '0; s_tag = '0;

      @(negedge clk);
      check("ready_in_reset", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", 64'(in_ready), 64'd1);
      check("count_after_reset", 64'(illegal_count), 64'd0);
      check("outs_after_reset", 64'({out_valid, out_vcc_wr_en, out_vgpr_wr_en, out_sgpr_wr_en,
            out_source_mux_select, out_vgpr_source_rd_en, out_sgpr_rd_en, out_exec_rd_en,
            out_illegal, out_tag}), 64'd0);
      @(posedge clk); #1;

      // VOP2 carry-out op with literal, VGPR and SGPR sources
      drive(F_VOP2, 12'h025, 12'h000, {12'hC03, 12'h805, L}, 6'd5);
      wait_accept(mk(3'b110, 12'h320, 3'b010, 1'b0, 6'd5));
      @(negedge clk);
      check("latency_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;

      // VOP3A compare with both destination overrides
      drive(F_VOP3A, 12'h081, 12'hE01, {L, L, L}, 6'd6);
      wait_accept(mk(3'b100, 12'h000, 3'b000, 1'b0, 6'd6));
      drive(F_VOP3A, 12'h081, 12'hC04, {L, L, L}, 6'd7);
      wait_accept(mk(3'b001, 12'h000, 3'b000, 1'b0, 6'd7));

      drive(F_VOPC, 12'h0C5, 12'h000, {12'hE08, 12'hE40, 12'h001}, 6'd8);
      wait_accept(mk(3'b100, 12'h7A1, 3'b000, 1'b0, 6'd8));
      drive(F_VOP1, 12'h001, 12'h000, {12'h3FF, 12'hD00, 12'h9FF}, 6'd9);
      wait_accept(mk(3'b010, 12'h132, 3'b001, 1'b0, 6'd9));
      drive(F_VOP3A, 12'h16A, 12'h000, {L, L, L}, 6'd3);
      wait_accept(mk(3'b010, 12'h000, 3'b000, 1'b0, 6'd3));

      // Unsupported opcode plus unsupported source
      drive(F_VOP2, 12'h0FF, 12'h000, {L, L, 12'hE03}, 6'd4);
      wait_accept(mk(3'b000, 12'h00F, 3'b000, 1'b1, 6'd4));
      @(negedge clk);
      check("illegal_count_1", 64'(illegal_count), 64'd1);
      drain();

      // Backpressure: third instruction held until the consumer drains
      out_ready = 1'b0;
      drive(F_VOP2, 12'h01B, 12'h000, {L, L, L}, 6'd10);
      wait_accept(mk(3'b010, 12'h000, 3'b000, 1'b0, 6'd10));
      drive(F_VOPC, 12'h087, 12'h000, {L, L, L}, 6'd11);
      wait_accept(mk(3'b100, 12'h000, 3'b000, 1'b0, 6'd11));
      drive(F_VOP3A, 12'h148, 12'h000, {L, L, L}, 6'd12);
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         check("full_not_ready", 64'(in_ready), 64'd0);
         check("full_head_tag", 64'(out_tag), 64'd10);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_accept(mk(3'b010, 12'h000, 3'b000, 1'b0, 6'd12));
      drain();

      // Reset with a full FIFO and a pending input
      out_ready = 1'b0;
      drive(F_VOP2, 12'h009, 12'h000, {L, L, L}, 6'd21);
      wait_accept(mk(3'b010, 12'h000, 3'b000, 1'b0, 6'd21));
      drive(F_VOP2, 12'h000, 12'h000, {L, L, L}, 6'd22);
      wait_accept(mk(3'b010, 12'h000, 3'b000, 1'b0, 6'd22));
      @(negedge clk);
      check("count_before_rst", 64'(illegal_count), 64'd1);
      @(posedge clk); #1;
      drive(F_VOP2, 12'h0FF, 12'h000, {L, L, L}, 6'd23);
      rst = 1'b1;
      @(negedge clk);
      check("ready_during_rst", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_count", 64'(illegal_count), 64'd0);
      check("rst_ready", 64'(in_ready), 64'd1);
      check("rst_out_tag", 64'(out_tag), 64'd0);
      @(negedge clk);
      check("rst_no_capture", 64'(out_valid), 64'd0);
      out_ready = 1'b1;

      // NUM_SRC=4 build: fourth source decoded as constant 0xE80
      @(posedge clk); #1;
      s_opcode = {F_VOP2, 12'h000, 12'h000};
      s_src    = {12'hE80, L, L, L};
      s_tag    = 6'd33;
      s_valid  = 1'b1;
      @(negedge clk);
      check("s_ready", 64'(s_ready), 64'd1);
      @(posedge clk); #1;
      s_valid = 1'b0;
      @(negedge clk);
      check("s_valid", 64'(s_out_valid), 64'd1);
      check("s_sel", 64'(s_sel), 64'hB000);
      check("s_rd", 64'(s_rd), 64'd0);
      check("s_we_ill", 64'({s_vcc, s_vgpr, s_sgpr, s_ill, s_out_tag}), 64'({4'b0100, 6'd33}));

      // CNT_W=3 build: 11 illegal accepts saturate at 7
      @(posedge clk); #1;
      s_opcode = {F_VOP1, 12'h000, 12'h0FF};
      s_valid  = 1'b1;
      acc = 0;
      for (int n = 0; n < 40 && acc < 11; n++) begin
         @(negedge clk);
         if (s_ready) acc++;
         if (acc == 11) begin
            @(posedge clk); #1;
            s_valid = 1'b0;
         end
      end
      if (acc < 11) s_valid = 1'b0;
      check("sat_accepts", 64'(acc), 64'd11);
      @(negedge clk);
      check("sat_count", 64'(s_count), 64'd7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
